// File: rtl/chrono48_start_core_pkg.sv
// rtl/chrono48_start_core_pkg.sv - shared constants, types and helpers for the start-channel core
package chrono48_start_core_pkg;

    localparam int CLKS_PER_BIT = 1302;

    localparam logic [7:0] CMD_RESET    = 8'h41;
    localparam logic [7:0] CMD_RST_DAC  = 8'h42;
    localparam logic [7:0] CMD_INC_DAC  = 8'h43;
    localparam logic [7:0] CMD_RST_TEST = 8'h45;
    localparam logic [7:0] CMD_STARTUP  = 8'h4C;
    localparam logic [1:0] SEL_PREFIX   = 2'b11;
    localparam logic [4:0] READ_PREFIX  = 5'b10000;

    typedef enum logic [1:0] {LINK_UC, LINK_PC, LINK_PR} link_t;
    typedef enum logic [1:0] {UART_IDLE, UART_START, UART_DATA, UART_STOP} uart_state_t;

    function automatic link_t link_decode(input logic [1:0] sel);
        case (sel)
            2'b01:   return LINK_PC;
            2'b10:   return LINK_PR;
            default: return LINK_UC;
        endcase
    endfunction

    // Bytes 6 and 7 fall in the zero padding above the 48-bit stamp.
    function automatic logic [7:0] ts_byte(input logic [47:0] ts, input logic [2:0] k);
        logic [63:0] wide;
        wide = {16'h0000, ts};
        return wide[{k, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/chrono48_start_core_uart_rx.sv
// rtl/chrono48_start_core_uart_rx.sv - 8N1 receiver, mid-bit sampling, glitch-rejecting start bit
module chrono48_start_core_uart_rx
    import chrono48_start_core_pkg::*;
#(
    parameter int CLKS_PER_BIT = chrono48_start_core_pkg::CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] m_tdata,
    output logic       m_tvalid
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    uart_state_t   state, state_nxt;
    logic [1:0]    rx_sync;
    logic          rx_s;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          cnt_clr, shift_en, frame_done;

    assign rx_s    = rx_sync[1];
    assign m_tdata = shift;

    always_ff @(posedge clk) begin
        if (rst) state <= UART_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            UART_IDLE:  if (!rx_s) state_nxt = UART_START;
            UART_START: if (clk_cnt == HALF_LAST) state_nxt = rx_s ? UART_IDLE : UART_DATA;
            UART_DATA:  if (clk_cnt == BIT_LAST && bit_idx == 3'd7) state_nxt = UART_STOP;
            UART_STOP:  if (clk_cnt == BIT_LAST) state_nxt = UART_IDLE;
            default:    state_nxt = UART_IDLE;
        endcase
    end

    always_comb begin
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        frame_done = 1'b0;
        case (state)
            UART_IDLE:  cnt_clr = 1'b1;
            UART_START: cnt_clr = (clk_cnt == HALF_LAST);
            UART_DATA: begin
                shift_en = (clk_cnt == BIT_LAST);
                cnt_clr  = (clk_cnt == BIT_LAST);
            end
            UART_STOP: begin
                frame_done = (clk_cnt == BIT_LAST);
                cnt_clr    = (clk_cnt == BIT_LAST);
            end
            default:    cnt_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync  <= 2'b11;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            m_tvalid <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], rx};
            clk_cnt  <= cnt_clr ? '0 : clk_cnt + CW'(1);
            m_tvalid <= frame_done;
            if (state == UART_IDLE) bit_idx <= '0;
            if (shift_en) begin
                shift   <= {rx_s, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

endmodule

// File: rtl/chrono48_start_core_uart_tx.sv
// rtl/chrono48_start_core_uart_tx.sv - 8N1 transmitter, one byte per 10 bit times
module chrono48_start_core_uart_tx
    import chrono48_start_core_pkg::*;
#(
    parameter int CLKS_PER_BIT = chrono48_start_core_pkg::CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    output logic       tx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

    uart_state_t   state, state_nxt;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          bit_end;

    assign bit_end = (clk_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= UART_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            UART_IDLE:  if (s_tvalid) state_nxt = UART_START;
            UART_START: if (bit_end) state_nxt = UART_DATA;
            UART_DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = UART_STOP;
            UART_STOP:  if (bit_end) state_nxt = UART_IDLE;
            default:    state_nxt = UART_IDLE;
        endcase
    end

    always_comb begin
        s_tready = 1'b0;
        tx       = 1'b1;
        case (state)
            UART_IDLE:  s_tready = 1'b1;
            UART_START: tx = 1'b0;
            UART_DATA:  tx = shift[0];
            default:    tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            clk_cnt <= (state == UART_IDLE || bit_end) ? '0 : clk_cnt + CW'(1);
            if (state == UART_IDLE && s_tvalid) begin
                shift   <= s_tdata;
                bit_idx <= '0;
            end else if (state == UART_DATA && bit_end) begin
                shift   <= {1'b1, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

endmodule

// File: rtl/chrono48_start_core.sv
// rtl/chrono48_start_core.sv - start timestamping, command decode, DAC PWM and serial link mux
module chrono48_start_core
    import chrono48_start_core_pkg::*;
#(
    parameter int CLKS_PER_BIT = chrono48_start_core_pkg::CLKS_PER_BIT,
    parameter int TEST_DELAY   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_pulse,
    input  logic [2:0] dev_addr,
    input  logic       rx_pc,
    input  logic       rx_uc,
    input  logic       rx_pr,
    input  logic       sel1,
    input  logic       sel0,
    output logic       clkout1,
    output logic       clkout2,
    output logic       startout1,
    output logic       startout2,
    output logic       intr,
    output logic       DACout,
    output logic       tx_pc,
    output logic       tx_uc,
    output logic       tx_pr,
    output logic       tst_stop_pulse,
    output logic       cmd_reset,
    output logic       cmd_rst_dac,
    output logic       cmd_inc_dac,
    output logic       cmd_dev_sel,
    output logic       cmd_rst_test
);

    localparam int TW = $clog2(TEST_DELAY + 1);

    link_t         link;
    logic          rx_line, tx_ser, tx_tready;
    logic [7:0]    rx_tdata;
    logic          rx_tvalid;
    logic          is_sel, sel_match, is_startup, is_read, read_go;
    logic [47:0]   counter, counter_nxt, timestamp;
    logic [2:0]    start_sync;
    logic [1:0]    holdoff;
    logic          start_go;
    logic [7:0]    dac_level, pwm_cnt;
    logic          selected, test_en, tst_act;
    logic [TW-1:0] tst_cnt;

    assign clkout1   = clk;
    assign clkout2   = clk;
    assign startout1 = start_pulse;
    assign startout2 = start_pulse;

    assign link = link_decode({sel1, sel0});

    always_comb begin
        case (link)
            LINK_PC: rx_line = rx_pc;
            LINK_PR: rx_line = rx_pr;
            default: rx_line = rx_uc;
        endcase
    end

    // Deselected transmit lines idle high so peers never see a start bit.
    assign tx_pc = (link == LINK_PC) ? tx_ser : 1'b1;
    assign tx_uc = (link == LINK_UC) ? tx_ser : 1'b1;
    assign tx_pr = (link == LINK_PR) ? tx_ser : 1'b1;

    chrono48_start_core_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx_line),
        .m_tdata  (rx_tdata),
        .m_tvalid (rx_tvalid)
    );

    chrono48_start_core_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (ts_byte(timestamp, rx_tdata[2:0])),
        .s_tvalid (is_read),
        .s_tready (tx_tready),
        .tx       (tx_ser)
    );

    assign cmd_reset    = rx_tvalid && rx_tdata == CMD_RESET;
    assign cmd_rst_dac  = rx_tvalid && rx_tdata == CMD_RST_DAC;
    assign cmd_inc_dac  = rx_tvalid && rx_tdata == CMD_INC_DAC;
    assign cmd_rst_test = rx_tvalid && rx_tdata == CMD_RST_TEST;
    assign is_startup   = rx_tvalid && rx_tdata == CMD_STARTUP;
    assign is_sel       = rx_tvalid && rx_tdata[7:6] == SEL_PREFIX;
    assign sel_match    = rx_tdata[2:0] == dev_addr;
    assign cmd_dev_sel  = is_sel && sel_match;
    assign is_read      = rx_tvalid && rx_tdata[7:3] == READ_PREFIX && selected;
    assign read_go      = is_read && tx_tready;

    assign counter_nxt = counter + 48'd1;
    // Holdoff merges edges closer than 3 clocks into one capture.
    assign start_go    = start_sync[1] && !start_sync[2] && holdoff == 2'd0;
    assign DACout      = pwm_cnt < dac_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            counter        <= '0;
            timestamp      <= '0;
            intr           <= 1'b0;
            start_sync     <= '0;
            holdoff        <= '0;
            dac_level      <= '0;
            pwm_cnt        <= '0;
            selected       <= 1'b0;
            test_en        <= 1'b0;
            tst_act        <= 1'b0;
            tst_cnt        <= '0;
            tst_stop_pulse <= 1'b0;
        end else begin
            counter    <= counter_nxt;
            pwm_cnt    <= pwm_cnt + 8'd1;
            start_sync <= {start_sync[1:0], start_pulse};

            if (start_go)              holdoff <= 2'd2;
            else if (holdoff != 2'd0)  holdoff <= holdoff - 2'd1;

            // Timestamp reads the counter as it stands after this edge.
            if (start_go) begin
                timestamp <= counter_nxt;
                intr      <= 1'b1;
            end else if (cmd_reset) begin
                timestamp <= '0;
                intr      <= 1'b0;
            end else if (read_go) begin
                intr      <= 1'b0;
            end

            if (cmd_reset || cmd_rst_test) test_en <= 1'b0;
            else if (is_startup)           test_en <= 1'b1;

            if (is_sel) selected <= sel_match;

            if (cmd_rst_dac)      dac_level <= '0;
            else if (cmd_inc_dac) dac_level <= dac_level + 8'd1;

            tst_stop_pulse <= 1'b0;
            if (cmd_reset || cmd_rst_test) begin
                tst_act <= 1'b0;
            end else if (start_go && test_en) begin
                tst_act <= 1'b1;
                tst_cnt <= TW'(TEST_DELAY - 1);
            end else if (tst_act) begin
                if (tst_cnt == '0) begin
                    tst_stop_pulse <= 1'b1;
                    tst_act        <= 1'b0;
                end else begin
                    tst_cnt <= tst_cnt - TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_chrono48_start_core.sv
// tb/tb_chrono48_start_core.sv - directed bench with transmit scoreboard for chrono48_start_core
module tb_chrono48_start_core;

    localparam int CPB  = 16;
    localparam int TDLY = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_pulse = 1'b0;
    logic [2:0] dev_addr = 3'd6;
    logic       rx_pc = 1'b1, rx_uc = 1'b1, rx_pr = 1'b1;
    logic       sel1 = 1'b0, sel0 = 1'b0;
    logic       clkout1, clkout2, startout1, startout2, intr, DACout;
    logic       tx_pc, tx_uc, tx_pr, tst_stop_pulse;
    logic       cmd_reset, cmd_rst_dac, cmd_inc_dac, cmd_dev_sel, cmd_rst_test;
    logic [2:0] tx_bus;

    int          checks = 0;
    int          errors = 0;
    logic [9:0]  exp_q[$];
    int          cyc = 0;
    int          frames[3];
    int          low_cnt[3];
    int          st_cnt[5];
    int          exp_st[5];
    int          tst_cnt = 0;
    int          tst_cyc = 0;
    logic        mon_off = 1'b0;
    logic [47:0] ts_exp = '0;

    chrono48_start_core #(.CLKS_PER_BIT(CPB), .TEST_DELAY(TDLY)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_pulse    (start_pulse),
        .dev_addr       (dev_addr),
        .rx_pc          (rx_pc),
        .rx_uc          (rx_uc),
        .rx_pr          (rx_pr),
        .sel1           (sel1),
        .sel0           (sel0),
        .clkout1        (clkout1),
        .clkout2        (clkout2),
        .startout1      (startout1),
        .startout2      (startout2),
        .intr           (intr),
        .DACout         (DACout),
        .tx_pc          (tx_pc),
        .tx_uc          (tx_uc),
        .tx_pr          (tx_pr),
        .tst_stop_pulse (tst_stop_pulse),
        .cmd_reset      (cmd_reset),
        .cmd_rst_dac    (cmd_rst_dac),
        .cmd_inc_dac    (cmd_inc_dac),
        .cmd_dev_sel    (cmd_dev_sel),
        .cmd_rst_test   (cmd_rst_test)
    );

    assign tx_bus = {tx_pr, tx_uc, tx_pc};

    always #40 clk = ~clk;

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    always @(negedge clk) begin
        if (cmd_reset)    st_cnt[0]++;
        if (cmd_rst_dac)  st_cnt[1]++;
        if (cmd_inc_dac)  st_cnt[2]++;
        if (cmd_dev_sel)  st_cnt[3]++;
        if (cmd_rst_test) st_cnt[4]++;
        if (tst_stop_pulse) begin
            tst_cnt++;
            tst_cyc = cyc;
        end
        for (int i = 0; i < 3; i++) if (!tx_bus[i]) low_cnt[i]++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mon_line(input int id);
        logic [7:0] b;
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (!rst && tx_bus[id] == 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx_bus[id];
                end
                repeat (CPB) @(negedge clk);
                if (!mon_off) begin
                    frames[id]++;
                    chk("tx_stop_bit", 64'(tx_bus[id]), 64'd1);
                    chk("tx_frame_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("tx_frame", 64'({2'(id), b}), 64'(e));
                    end
                end
            end
        end
    endtask

    task automatic set_rx(input int id, input logic v);
        case (id)
            0:       rx_pc = v;
            1:       rx_uc = v;
            default: rx_pr = v;
        endcase
    endtask

    task automatic send_byte(input int id, input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            set_rx(id, fr[i]);
            repeat (CPB) @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_strobes(input string tag);
        chk(tag, 64'({8'(st_cnt[0]), 8'(st_cnt[1]), 8'(st_cnt[2]), 8'(st_cnt[3]), 8'(st_cnt[4])}),
                 64'({8'(exp_st[0]), 8'(exp_st[1]), 8'(exp_st[2]), 8'(exp_st[3]), 8'(exp_st[4])}));
    endtask

    task automatic wait_tx();
        for (int i = 0; i < 20 * CPB && exp_q.size() != 0; i++) @(negedge clk);
        chk("tx_done", 64'(exp_q.size()), 64'd0);
        repeat (CPB) @(negedge clk);
    endtask

    task automatic read_byte(input int id, input int k);
        logic [7:0] eb;
        eb = (k < 6) ? 8'(ts_exp >> (8 * k)) : 8'h00;
        exp_q.push_back({2'(id), eb});
        send_byte(id, 8'h80 | 8'(k));
        wait_tx();
    endtask

    task automatic do_start(output int n);
        n = cyc;
        start_pulse = 1'b1;
        repeat (3) @(negedge clk);
        start_pulse = 1'b0;
        ts_exp = 48'(n + 3);
    endtask

    task automatic duty(output int h);
        h = 0;
        repeat (256) begin
            @(negedge clk);
            h += int'(DACout);
        end
    endtask

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n, h, f, t0, lu, lp;
        fork
            mon_line(0);
            mon_line(1);
            mon_line(2);
        join_none

        repeat (5) @(negedge clk);
        chk("reset_tx", 64'(tx_bus), 64'h7);
        chk("reset_intr_tst_dac", 64'({intr, tst_stop_pulse, DACout}), 64'd0);
        chk("reset_strobes", 64'({cmd_reset, cmd_rst_dac, cmd_inc_dac, cmd_dev_sel, cmd_rst_test}), 64'd0);
        chk("clkout_copy", 64'({clkout1, clkout2}), 64'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // 100 ns start pulse; capture visible 3 clocks after the rise
        n = cyc;
        start_pulse = 1'b1;
        #1 chk("startout_high", 64'({startout1, startout2}), 64'h3);
        @(negedge clk);
        chk("intr_lat1", 64'(intr), 64'd0);
        #20 start_pulse = 1'b0;
        #1 chk("startout_low", 64'({startout1, startout2}), 64'h0);
        @(negedge clk);
        chk("intr_lat2", 64'(intr), 64'd0);
        @(negedge clk);
        chk("intr_set", 64'(intr), 64'd1);
        ts_exp = 48'(n + 3);
        repeat (4) @(negedge clk);

        send_byte(1, 8'hC6);
        exp_st[3]++;
        check_strobes("strobe_dev_sel");
        read_byte(1, 0);
        chk("intr_cleared", 64'(intr), 64'd0);
        read_byte(1, 1);

        send_byte(1, 8'h41);
        exp_st[0]++;
        check_strobes("strobe_reset");
        send_byte(1, 8'h42);
        exp_st[1]++;
        check_strobes("strobe_rst_dac");
        duty(h);
        chk("dac_duty_0", 64'(h), 64'd0);
        send_byte(1, 8'h43);
        exp_st[2]++;
        check_strobes("strobe_inc_dac");
        duty(h);
        chk("dac_duty_1", 64'(h), 64'd1);

        send_byte(1, 8'h45);
        exp_st[4]++;
        check_strobes("strobe_rst_test");
        send_byte(1, 8'h4C);
        check_strobes("startup_no_strobe");
        t0 = tst_cnt;
        do_start(n);
        repeat (30) @(negedge clk);
        chk("tst_pulse_count", 64'(tst_cnt - t0), 64'd1);
        chk("tst_pulse_time", 64'(tst_cyc), 64'(n + 3 + TDLY));
        chk("intr_after_start", 64'(intr), 64'd1);

        for (int k = 0; k < 5; k++) read_byte(1, k);
        chk("intr_cleared_reads", 64'(intr), 64'd0);
        read_byte(1, 6);

        send_byte(1, 8'hC5);
        check_strobes("dev_sel_mismatch");
        f = frames[1];
        send_byte(1, 8'h80);
        repeat (12 * CPB) @(negedge clk);
        chk("deselected_no_tx", 64'(frames[1]), 64'(f));

        sel0 = 1'b1;
        repeat (4) @(negedge clk);
        lu = low_cnt[1];
        lp = low_cnt[2];
        send_byte(1, 8'h41);
        check_strobes("unselected_rx_ignored");
        send_byte(0, 8'hC6);
        exp_st[3]++;
        check_strobes("pc_dev_sel");
        read_byte(0, 1);
        chk("uc_pr_idle", 64'({8'(low_cnt[1] - lu), 8'(low_cnt[2] - lp)}), 64'd0);

        // reset in the middle of a response frame
        sel0 = 1'b0;
        repeat (4) @(negedge clk);
        mon_off = 1'b1;
        send_byte(1, 8'h80);
        for (int i = 0; i < 20 * CPB && tx_uc; i++) @(negedge clk);
        chk("tx_frame_started", 64'(tx_uc), 64'd0);
        repeat (3 * CPB) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_tx_high", 64'(tx_bus), 64'h7);
        chk("rst_intr_tst", 64'({intr, tst_stop_pulse}), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        mon_off = 1'b0;
        check_strobes("rst_no_strobes");
        duty(h);
        chk("rst_dac_level", 64'(h), 64'd0);

        f = frames[1];
        send_byte(1, 8'h80);
        repeat (12 * CPB) @(negedge clk);
        chk("rst_deselected", 64'(frames[1]), 64'(f));
        send_byte(1, 8'hC6);
        exp_st[3]++;
        ts_exp = '0;
        read_byte(1, 0);
        t0 = tst_cnt;
        do_start(n);
        repeat (30) @(negedge clk);
        chk("rst_test_disabled", 64'(tst_cnt - t0), 64'd0);
        read_byte(1, 0);
        read_byte(1, 1);
        check_strobes("final_strobes");
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
